// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sequential N-tap FIR with one shared MAC, circular sample history,
// runtime-writable coefficients and a valid/ready result port.
module fir_seq_ctrl #(
  parameter int N     = 11,
  parameter int WIDTH = 32,
  localparam int AW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  input  logic             coef_we,
  input  logic [AW-1:0]    coef_addr,
  input  logic [WIDTH-1:0] coef_wdata,
  output logic             coef_rej,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y_out,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  localparam logic [AW:0] NL = (AW+1)'(N);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_hist [N];
  logic [WIDTH-1:0] r_coef [N];
  logic [AW-1:0]    r_wp, r_k;
  logic [WIDTH-1:0] r_acc, r_y;
  logic             r_rej;
  logic             w_last, w_addr_ok, w_accept;
  logic [AW:0]      w_wrap;
  logic [AW-1:0]    w_idx;
  logic [WIDTH-1:0] w_prod, w_sum;

  assign w_last    = r_k == AW'(N - 1);
  assign w_addr_ok = {1'b0, coef_addr} < NL;
  assign w_accept  = r_state == IDLE && in_valid;
  // hist[wp] is the newest sample, so tap k reads (wp - k) mod N
  assign w_wrap    = {1'b0, r_wp} + NL - {1'b0, r_k};
  assign w_idx     = (r_wp >= r_k) ? r_wp - r_k : w_wrap[AW-1:0];
  assign w_prod    = r_coef[r_k] * r_hist[w_idx];
  assign w_sum     = r_acc + w_prod;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;

  always_comb begin
    w_next    = r_state;
    in_ready  = r_state == IDLE;
    out_valid = r_state == OUT;
    busy      = r_state != IDLE;
    coef_rej  = r_rej;
    y_out     = r_y;
    if (w_accept) w_next = MAC;
    else if (r_state == MAC && w_last) w_next = OUT;
    else if (r_state == OUT && out_ready) w_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_hist[i] <= '0;
        r_coef[i] <= WIDTH'((i + 1 < N - i) ? i + 1 : N - i);
      end
      r_wp  <= '0;
      r_k   <= '0;
      r_acc <= '0;
      r_y   <= '0;
      r_rej <= 1'b0;
    end else begin
      r_rej <= coef_we && (!w_addr_ok || r_state == MAC);
      if (coef_we && w_addr_ok && r_state != MAC) r_coef[coef_addr] <= coef_wdata;
      if (w_accept) begin
        r_hist[r_wp] <= x_in;
        r_acc        <= '0;
        r_k          <= '0;
      end
      if (r_state == MAC) begin
        r_acc <= w_sum;
        r_k   <= w_last ? '0 : r_k + 1'b1;
        if (w_last) begin
          r_y  <= w_sum;
          r_wp <= (r_wp == AW'(N - 1)) ? '0 : r_wp + 1'b1;
        end
      end
    end
endmodule
